ros2rapper_tx_scheduler: RTL

//  Arbitrates ROS2rapper TX traffic. Consumes the elapsed flags of the TX period/interval counters.

---
 rtl/ros2rapper_tx_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ros2rapper_tx_scheduler.sv
// rtl/ros2rapper_tx_scheduler.sv - round-robin TX kind scheduler with req/ack/done handshake
// Grants one elapsed message kind at a time to the packet generator and re-arms its counters.
module ros2rapper_tx_scheduler #(
  parameter logic [7:0] KIND_MASK  = 8'hFF,
  parameter int         TX_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_sedp_en,
  input  logic       i_app_wr_req,
  input  logic       i_cnt_interval_elapsed,
  input  logic [7:0] i_cnt_elapsed,
  output logic       o_cnt_interval_set,
  output logic [7:0] o_cnt_set,
  output logic       o_tx_req,
  output logic [2:0] o_tx_kind,
  input  logic       i_tx_ack,
  input  logic       i_tx_done,
  output logic       o_tx_timeout,
  output logic       o_busy
);

  localparam int CW = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TX_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    kind_q, kind_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d;
  logic [7:0]    set_q, set_d;
  logic          iset_q, iset_d;
  logic          tout_q, tout_d;
  logic          busy_q, busy_d;

  logic [7:0] elig;
  logic       grant_vld;
  logic [2:0] grant_kind;
  logic [2:0] idx;
  logic       finish_now;
  logic       finish_tmo;

  // Kind 0 (SPDP) needs no discovery; SEDP kinds need a remote participant; APP needs pending data.
  assign elig = i_cnt_elapsed & KIND_MASK & {i_app_wr_req, {6{i_sedp_en}}, 1'b1};

  // Scan downward in offset so the closest eligible kind at or above ptr wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_kind = ptr_q;
    idx        = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (elig[idx]) begin
        grant_vld  = 1'b1;
        grant_kind = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    ptr_d      = ptr_q;
    tmo_d      = tmo_q;
    req_d      = req_q;
    set_d      = 8'h00;
    iset_d     = 1'b0;
    tout_d     = 1'b0;
    finish_now = 1'b0;
    finish_tmo = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_cnt_interval_elapsed && grant_vld) begin
          state_d = ST_REQ;
          kind_d  = grant_kind;
          req_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        if (i_tx_ack && i_tx_done) begin
          finish_now = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          finish_now = 1'b1;
          finish_tmo = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
          if (i_tx_ack) begin
            req_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          finish_now = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          finish_now = 1'b1;
          finish_tmo = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set pulses are registered on entry so they are visible exactly during FINISH.
    if (finish_now) begin
      state_d = ST_FINISH;
      req_d   = 1'b0;
      set_d   = 8'h01 << kind_q;
      iset_d  = 1'b1;
      tout_d  = finish_tmo;
      ptr_d   = kind_q + 3'd1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= 3'd0;
      ptr_q   <= 3'd0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      set_q   <= 8'h00;
      iset_q  <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      set_q   <= set_d;
      iset_q  <= iset_d;
      tout_q  <= tout_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx_req           = req_q;
  assign o_tx_kind          = kind_q;
  assign o_cnt_set          = set_q;
  assign o_cnt_interval_set = iset_q;
  assign o_tx_timeout       = tout_q;
  assign o_busy             = busy_q;

endmodule
